// File: rtl/result_readback.sv
// ---------------------------------------------------------------------------
// result_readback
//
// Capture buffer for the demodulator's 80-bit result beats. After an arm
// command and a rising edge on trigger_in[0], up to TARGET beats are stored
// in on-chip RAM. The host reads them back, together with a small register
// set, over the 33-bit PcPort MEM interface.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   res_data_0..4, res_valid  result beat (word 0 = bits [15:0]) and valid
//   trigger_in                trigger bus, bit 0 starts a capture
//   MEM_sdi_mem_S_*           host address / read / write strobes / data
//   MEM_sdi_mem_M_rdData      read data, [32] = read-valid (1 cycle after rdEn)
//   capture_done              one-cycle pulse after entering DONE
//   armed                     high while ARMED or CAPTURE
//
// Address map: 0x0000-0x1FFF buffer (entry = addr[12:3], word = addr[2:0]),
// 0x2000 CTRL (wo: bit0 arm, bit1 clear), 0x2001 STATUS (ro), 0x2002 TARGET.
// ---------------------------------------------------------------------------
module result_readback #(
    parameter int DEPTH = 256,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] res_data_0,
    input  logic [15:0] res_data_1,
    input  logic [15:0] res_data_2,
    input  logic [15:0] res_data_3,
    input  logic [15:0] res_data_4,
    input  logic        res_valid,
    input  logic [4:0]  trigger_in,
    input  logic [13:0] MEM_sdi_mem_S_address,
    input  logic        MEM_sdi_mem_S_rdEn,
    input  logic        MEM_sdi_mem_S_wrEn,
    input  logic [32:0] MEM_sdi_mem_S_wrData,
    output logic [32:0] MEM_sdi_mem_M_rdData,
    output logic        capture_done,
    output logic        armed
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [10:0] DEPTH_L = 11'(DEPTH);
    localparam logic [13:0] ADDR_CTRL   = 14'h2000;
    localparam logic [13:0] ADDR_STATUS = 14'h2001;
    localparam logic [13:0] ADDR_TARGET = 14'h2002;

    localparam logic [1:0] SRC_ZERO = 2'd0;
    localparam logic [1:0] SRC_BUF  = 2'd1;
    localparam logic [1:0] SRC_REG  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Bits of the host bus / trigger that carry no function here.
    logic unused_bits;
    assign unused_bits = ^{trigger_in[4:1], MEM_sdi_mem_S_wrData[32:16]};

    // ------------------------------------------------------------------
    // Beat packing
    // ------------------------------------------------------------------
    logic [15:0] res_word [5];
    logic [79:0] beat;

    assign res_word[0] = res_data_0;
    assign res_word[1] = res_data_1;
    assign res_word[2] = res_data_2;
    assign res_word[3] = res_data_3;
    assign res_word[4] = res_data_4;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_pack
            assign beat[16*gi +: 16] = res_word[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   target_q, target_d;
    logic          trig_prev_q;
    logic          capture_done_q, armed_q;

    logic          trig_edge;
    logic          ctrl_wr, arm_cmd, clr_cmd;
    logic          beat_we;
    logic [CW-1:0] eff_target;
    logic [CW-1:0] count_inc;

    assign trig_edge = trigger_in[0] & ~trig_prev_q;
    assign ctrl_wr   = MEM_sdi_mem_S_wrEn && (MEM_sdi_mem_S_address == ADDR_CTRL);
    assign arm_cmd   = ctrl_wr & MEM_sdi_mem_S_wrData[0];
    assign clr_cmd   = ctrl_wr & MEM_sdi_mem_S_wrData[1];
    assign count_inc = count_q + CW'(1);

    // 0 or anything larger than the buffer means "fill the whole buffer".
    assign eff_target = ((target_q == 16'd0) || (target_q > 16'(DEPTH)))
                        ? CW'(DEPTH) : CW'(target_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        target_d = target_q;
        beat_we  = 1'b0;

        if (MEM_sdi_mem_S_wrEn && (MEM_sdi_mem_S_address == ADDR_TARGET)) begin
            target_d = MEM_sdi_mem_S_wrData[15:0];
        end

        if (clr_cmd) begin
            // Clear beats arm in the same write; RAM is left untouched.
            state_d = S_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm_cmd) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (trig_edge) begin
                        state_d = S_CAPTURE;
                        beat_we = res_valid;
                    end
                end
                S_CAPTURE: begin
                    beat_we = res_valid;
                end
                S_DONE: begin
                    if (arm_cmd) begin
                        state_d = S_ARMED;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else if (res_valid) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // The count doubles as the write pointer. A lowered target that
            // the count already meets finishes on the next stored beat.
            if (beat_we) begin
                count_d = count_inc;
                if (count_inc >= eff_target) state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            target_q       <= 16'd0;
            trig_prev_q    <= 1'b0;
            capture_done_q <= 1'b0;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            target_q       <= target_d;
            trig_prev_q    <= trigger_in[0];
            capture_done_q <= (state_d == S_DONE) && (state_q != S_DONE);
            armed_q        <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
        end
    end

    assign capture_done = capture_done_q;
    assign armed        = armed_q;

    // ------------------------------------------------------------------
    // Capture RAM: write port from the beat stream, registered read port
    // for the host. Read-during-write returns the old word.
    // ------------------------------------------------------------------
    logic [79:0] buf_mem [DEPTH];
    logic [79:0] ram_rd_q;
    logic [AW-1:0] rd_idx;

    assign rd_idx = MEM_sdi_mem_S_address[3 +: AW];

    always_ff @(posedge clk) begin
        if (beat_we) buf_mem[count_q[AW-1:0]] <= beat;
        if (MEM_sdi_mem_S_rdEn) ram_rd_q <= buf_mem[rd_idx];
    end

    // ------------------------------------------------------------------
    // Host read decode: source, word select and register value are all
    // captured with rdEn so the output holds until the next read.
    // ------------------------------------------------------------------
    logic [1:0]  rd_src_q, rd_src_d;
    logic [2:0]  rd_word_q, rd_word_d;
    logic [31:0] rd_reg_q, rd_reg_d;
    logic        rd_valid_q;
    logic        entry_in_range;

    assign entry_in_range = {1'b0, MEM_sdi_mem_S_address[12:3]} < DEPTH_L;

    always_comb begin
        rd_src_d  = SRC_ZERO;
        rd_word_d = MEM_sdi_mem_S_address[2:0];
        rd_reg_d  = 32'd0;
        if (!MEM_sdi_mem_S_address[13]) begin
            if (entry_in_range && (MEM_sdi_mem_S_address[2:0] <= 3'd4)) begin
                rd_src_d = SRC_BUF;
            end
        end else begin
            rd_src_d = SRC_REG;
            case (MEM_sdi_mem_S_address)
                ADDR_STATUS: rd_reg_d = {16'(count_q), 13'd0, ovf_q, state_q};
                ADDR_TARGET: rd_reg_d = {16'd0, target_q};
                default:     rd_reg_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_src_q   <= SRC_ZERO;
            rd_word_q  <= 3'd0;
            rd_reg_q   <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= MEM_sdi_mem_S_rdEn;
            if (MEM_sdi_mem_S_rdEn) begin
                rd_src_q  <= rd_src_d;
                rd_word_q <= rd_word_d;
                rd_reg_q  <= rd_reg_d;
            end
        end
    end

    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'd0;
        case (rd_src_q)
            SRC_BUF: begin
                case (rd_word_q)
                    3'd0:    rd_data = {16'd0, ram_rd_q[15:0]};
                    3'd1:    rd_data = {16'd0, ram_rd_q[31:16]};
                    3'd2:    rd_data = {16'd0, ram_rd_q[47:32]};
                    3'd3:    rd_data = {16'd0, ram_rd_q[63:48]};
                    3'd4:    rd_data = {16'd0, ram_rd_q[79:64]};
                    default: rd_data = 32'd0;
                endcase
            end
            SRC_REG: rd_data = rd_reg_q;
            default: rd_data = 32'd0;
        endcase
    end

    assign MEM_sdi_mem_M_rdData = {rd_valid_q, rd_data};

endmodule

// File: tb/tb_result_readback.sv
module tb_result_readback;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] res_data_0 = '0, res_data_1 = '0, res_data_2 = '0,
                 res_data_3 = '0, res_data_4 = '0;
    logic        res_valid = 1'b0;
    logic [4:0]  trigger_in = '0;
    logic [13:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [32:0] wr_data = '0;
    logic [32:0] rd_data;
    logic        capture_done;
    logic        armed;

    result_readback #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .res_data_0            (res_data_0),
        .res_data_1            (res_data_1),
        .res_data_2            (res_data_2),
        .res_data_3            (res_data_3),
        .res_data_4            (res_data_4),
        .res_valid             (res_valid),
        .trigger_in            (trigger_in),
        .MEM_sdi_mem_S_address (addr),
        .MEM_sdi_mem_S_rdEn    (rd_en),
        .MEM_sdi_mem_S_wrEn    (wr_en),
        .MEM_sdi_mem_S_wrData  (wr_data),
        .MEM_sdi_mem_M_rdData  (rd_data),
        .capture_done          (capture_done),
        .armed                 (armed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: buffer contents, count, overflow and phase kept
    // as plain integers, updated once per clock from the sampled inputs.
    // ------------------------------------------------------------------
    logic [79:0] m_mem [DEPTH];
    int          m_state = 0;      // 0 idle, 1 armed, 2 capture, 3 done
    int          m_count = 0;
    bit          m_ovf = 1'b0;
    logic [15:0] m_target = '0;
    bit          m_trig_prev = 1'b0;
    bit          m_rdv = 1'b0;
    logic [31:0] m_rdd = '0;
    bit          m_done = 1'b0;
    bit          m_armed = 1'b0;

    function automatic logic [31:0] m_read(input logic [13:0] a);
        int entry, w;
        if (a[13] == 1'b0) begin
            entry = int'(a[12:3]);
            w = int'(a[2:0]);
            if (entry >= DEPTH || w > 4) return 32'd0;
            return {16'd0, m_mem[entry][w*16 +: 16]};
        end
        if (a == 14'h2001) return {16'(m_count), 13'd0, m_ovf, 2'(m_state)};
        if (a == 14'h2002) return {16'd0, m_target};
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        int  old_state, eff;
        bit  edge_seen, ctrl, store;
        if (rst) begin
            m_state = 0; m_count = 0; m_ovf = 0; m_target = '0;
            m_trig_prev = 0; m_rdv = 0; m_rdd = '0; m_done = 0; m_armed = 0;
        end else begin
            if (rd_en) begin m_rdv = 1; m_rdd = m_read(addr); end
            else m_rdv = 0;
            old_state = m_state;
            edge_seen = trigger_in[0] && !m_trig_prev;
            eff = (m_target == 0 || int'(m_target) > DEPTH) ? DEPTH : int'(m_target);
            ctrl = wr_en && addr == 14'h2000;
            store = 0;
            if (ctrl && wr_data[1]) begin
                m_state = 0; m_count = 0; m_ovf = 0;
            end else begin
                case (m_state)
                    0: if (ctrl && wr_data[0]) m_state = 1;
                    1: if (edge_seen) begin m_state = 2; store = res_valid; end
                    2: store = res_valid;
                    default: begin
                        if (ctrl && wr_data[0]) begin m_state = 1; m_count = 0; m_ovf = 0; end
                        else if (res_valid) m_ovf = 1;
                    end
                endcase
                if (store) begin
                    m_mem[m_count] = {res_data_4, res_data_3, res_data_2, res_data_1, res_data_0};
                    m_count++;
                    if (m_count >= eff) m_state = 3;
                end
            end
            if (wr_en && addr == 14'h2002) m_target = wr_data[15:0];
            m_done = (m_state == 3) && (old_state != 3);
            m_armed = (m_state == 1) || (m_state == 2);
            m_trig_prev = trigger_in[0];
        end
        started = 1'b1;
    end

    // Compare process: every cycle once the model has seen a clock edge.
    always @(negedge clk) begin
        if (started) begin
            check("rdData", rd_data, {m_rdv, m_rdd});
            check("capture_done", {32'd0, capture_done}, {32'd0, m_done});
            check("armed", {32'd0, armed}, {32'd0, m_armed});
            if (capture_done) done_pulses++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [79:0] b);
        {res_data_4, res_data_3, res_data_2, res_data_1, res_data_0} = b;
    endtask

    task automatic send_beat(input logic [79:0] b, input logic trig);
        set_beat(b);
        res_valid = 1'b1;
        trigger_in[0] = trig;
        step();
        res_valid = 1'b0;
    endtask

    task automatic reg_write(input logic [13:0] a, input logic [31:0] d);
        addr = a; wr_data = {1'b0, d}; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic read_expect(input logic [13:0] a, input logic [31:0] exp, input string name);
        addr = a; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        @(negedge clk);
        check(name, rd_data, {1'b1, exp});
    endtask

    function automatic logic [79:0] gen(input int i);
        logic [79:0] r;
        for (int k = 0; k < 5; k++) r[16*k +: 16] = 16'((k << 12) | (i & 12'hFFF));
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        step(); step(); step();
        rst = 1'b0;
        step();
        read_expect(14'h2001, 32'h0000_0000, "status_reset");
        read_expect(14'h2002, 32'h0000_0000, "target_reset");

        // Test 1: TARGET=4, two early beats discarded, capture A..D, E drops
        reg_write(14'h2002, 32'd4);
        reg_write(14'h2000, 32'h1);
        read_expect(14'h2001, 32'h0000_0001, "status_armed");
        send_beat(80'hFFFF_FFFE_FFFD_FFFC_FFFB, 1'b0);
        send_beat(80'hEEE4_EEE3_EEE2_EEE1_EEE0, 1'b0);
        send_beat(80'hAAA4_AAA3_AAA2_AAA1_AAA0, 1'b1);
        send_beat(80'hBBB4_BBB3_BBB2_BBB1_BBB0, 1'b0);
        send_beat(80'h1234_5678_9ABC_DEF0_1357, 1'b0);
        send_beat(80'hDDD4_DDD3_DDD2_DDD1_DDD0, 1'b0);
        send_beat(80'h5554_5553_5552_5551_5550, 1'b0);
        step();
        read_expect(14'h2001, 32'h0004_0007, "status_done4");
        check("done_pulses_t1", 33'(done_pulses), 33'd1);
        read_expect(14'h0000, 32'h0000_AAA0, "entry0_w0");
        read_expect(14'h0008, 32'h0000_BBB0, "entry1_w0");
        read_expect(14'h0011, 32'h0000_DEF0, "entry2_w1");
        read_expect(14'h0015, 32'h0000_0000, "entry2_w5");
        read_expect(14'h0014, 32'h0000_1234, "entry2_w4");
        read_expect(14'h0018, 32'h0000_DDD0, "entry3_w0");
        read_expect(14'h2000, 32'h0000_0000, "ctrl_reads_0");

        // Test 3: TARGET=0 fills whole buffer, beat 257 sets overflow
        reg_write(14'h2000, 32'h2);
        reg_write(14'h2002, 32'd0);
        reg_write(14'h2000, 32'h1);
        for (int i = 0; i <= DEPTH; i++) send_beat(gen(i), (i < 3) ? 1'b1 : 1'b0);
        trigger_in[0] = 1'b0;
        step();
        read_expect(14'h2001, 32'h0100_0007, "status_full");
        read_expect(14'(255 << 3), 32'h0000_00FF, "entry255_w0");
        read_expect(14'(255 << 3) + 14'd3, 32'h0000_30FF, "entry255_w3");
        read_expect(14'h0800, 32'h0000_0000, "entry256_oob");
        check("done_pulses_t3", 33'(done_pulses), 33'd2);

        // Test 4: simultaneous rd/wr of TARGET, then clear mid-capture
        addr = 14'h2002; wr_data = 33'd20; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check("target_rdwr_old", rd_data, {1'b1, 32'd0});
        reg_write(14'h2000, 32'h1);
        for (int i = 0; i < 10; i++) send_beat(gen(32'h200 + i), (i == 0) ? 1'b1 : 1'b0);
        read_expect(14'h2001, 32'h000A_0002, "status_cap10");
        reg_write(14'h2000, 32'h3);
        read_expect(14'h2001, 32'h0000_0000, "status_cleared");
        read_expect(14'h0048, 32'h0000_0209, "entry9_after_clr");
        read_expect(14'h0002, 32'h0000_2200, "entry0_w2_after_clr");

        // Test 6: read entry 5 on the cycle it is written
        reg_write(14'h2000, 32'h1);
        for (int i = 0; i < 5; i++) send_beat(gen(32'h300 + i), (i == 0) ? 1'b1 : 1'b0);
        addr = 14'h0028; rd_en = 1'b1;
        send_beat(gen(32'h305), 1'b0);
        rd_en = 1'b0;
        @(negedge clk);
        check("rdw_old_data", rd_data, {1'b1, 32'h0000_0205});
        read_expect(14'h0028, 32'h0000_0305, "rdw_new_data");

        // Test 5: reset mid-capture with trigger held high
        trigger_in[0] = 1'b1;
        step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        read_expect(14'h2001, 32'h0000_0000, "status_after_rst");
        read_expect(14'h2002, 32'h0000_0000, "target_after_rst");
        reg_write(14'h2000, 32'h1);
        for (int i = 0; i < 3; i++) send_beat(gen(32'h3F0 + i), 1'b1);
        read_expect(14'h2001, 32'h0000_0001, "no_capture_held_trig");
        trigger_in[0] = 1'b0;
        step();
        for (int i = 0; i < 3; i++) send_beat(gen(32'h400 + i), 1'b1);
        read_expect(14'h2001, 32'h0003_0002, "capture_after_retrig");
        read_expect(14'h0010, 32'h0000_0402, "entry2_after_retrig");
        check("done_pulses_end", 33'(done_pulses), 33'd2);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
